// File: rtl/lcd_frame_fetch_if.sv
// SDRAM burst-read port between lcd_frame_fetch (master) and the memory controller (slave).
interface lcd_frame_fetch_if #(
    parameter int ADDR_W = 24
) ();
    logic              mem_rd_req;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic              mem_rd_ack;
    logic              mem_rd_valid;
    logic [15:0]       mem_rd_data;

    modport master (
        output mem_rd_req, mem_rd_addr,
        input  mem_rd_ack, mem_rd_valid, mem_rd_data
    );

    modport slave (
        input  mem_rd_req, mem_rd_addr,
        output mem_rd_ack, mem_rd_valid, mem_rd_data
    );
endinterface

// File: rtl/lcd_frame_fetch.sv
// Pixel prefetch FIFO feeding the LCD timing driver from burst SDRAM reads.
// Optional saturating underflow counter is built only when LCD_FETCH_UFCNT_EN is defined.
//
// state | meaning
// IDLE  | waiting for FIFO space and frame pixels still to fetch
// REQ   | mem_rd_req held until mem_rd_ack
// DATA  | accepting BURST_LEN beats into the FIFO
// DRAIN | discarding the rest of a burst made stale by TFT_begin
module lcd_frame_fetch #(
    parameter int               H_DISP          = 480,
    parameter int               V_DISP          = 272,
    parameter int               FIFO_DEPTH      = 64,
    parameter int               BURST_LEN       = 16,
    parameter int               ADDR_W          = 24,
    parameter logic [ADDR_W-1:0] BASE_ADDR      = '0,
    parameter logic [15:0]      UNDERFLOW_PIXEL = 16'hF800
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     TFT_begin,
    input  logic                     lcd_request,
    output logic [15:0]              lcd_data,
    lcd_frame_fetch_if.master        mem,
    output logic                     underflow,
    output logic [15:0]              underflow_cnt
);

    localparam int TOTAL   = H_DISP * V_DISP;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int FETCH_W = $clog2(TOTAL + 1);
    localparam int BEAT_W  = $clog2(BURST_LEN) + 1;

    localparam logic [CNT_W-1:0]   DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]   BURST_C   = CNT_W'(BURST_LEN);
    localparam logic [FETCH_W-1:0] TOTAL_C   = FETCH_W'(TOTAL);
    localparam logic [FETCH_W-1:0] BURST_F   = FETCH_W'(BURST_LEN);
    localparam logic [ADDR_W-1:0]  BURST_A   = ADDR_W'(BURST_LEN);
    localparam logic [BEAT_W-1:0]  LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] REQ   = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    logic [1:0]         state;
    logic [CNT_W-1:0]   fifo_cnt;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [15:0]        fifo_mem [FIFO_DEPTH];
    logic [FETCH_W-1:0] fetched;
    logic [BEAT_W-1:0]  beat_cnt;
    logic               stale;

    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_free;
    logic               can_fetch;
    logic               beat;
    logic               push;
    logic               pop;
    logic               last_beat;

    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_free  = DEPTH_C - fifo_cnt;
    assign can_fetch  = (fifo_free >= BURST_C) && (fetched < TOTAL_C);
    assign beat       = mem.mem_rd_valid && ((state == DATA) || (state == DRAIN));
    assign push       = beat && (state == DATA) && !TFT_begin;
    assign pop        = lcd_request && !fifo_empty && !TFT_begin;
    assign last_beat  = beat && (beat_cnt == LAST_BEAT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else if (TFT_begin) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= mem.mem_rd_data;
    end

    // A request coinciding with the frame flush returns 0 and is not an underflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lcd_data  <= '0;
            underflow <= 1'b0;
        end else begin
            if (TFT_begin)
                underflow <= 1'b0;
            else if (lcd_request && fifo_empty)
                underflow <= 1'b1;

            if (lcd_request) begin
                if (TFT_begin)
                    lcd_data <= '0;
                else if (fifo_empty)
                    lcd_data <= UNDERFLOW_PIXEL;
                else
                    lcd_data <= fifo_mem[rd_ptr];
            end
        end
    end

`ifdef LCD_FETCH_UFCNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            underflow_cnt <= '0;
        else if (lcd_request && fifo_empty && !TFT_begin && (underflow_cnt != 16'hFFFF))
            underflow_cnt <= underflow_cnt + 16'd1;
    end
`else
    assign underflow_cnt = '0;
`endif

    // A request outstanding at frame start keeps its address on the bus until acked;
    // the reload to BASE_ADDR happens at the ack and the burst is drained uncounted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            mem.mem_rd_req  <= 1'b0;
            mem.mem_rd_addr <= BASE_ADDR;
            fetched         <= '0;
            beat_cnt        <= '0;
            stale           <= 1'b0;
        end else begin
            if (TFT_begin) fetched <= '0;
            case (state)
                IDLE: begin
                    beat_cnt <= '0;
                    if (TFT_begin) begin
                        state           <= REQ;
                        mem.mem_rd_req  <= 1'b1;
                        mem.mem_rd_addr <= BASE_ADDR;
                    end else if (can_fetch) begin
                        state          <= REQ;
                        mem.mem_rd_req <= 1'b1;
                    end
                end
                REQ: begin
                    if (mem.mem_rd_ack) begin
                        mem.mem_rd_req <= 1'b0;
                        beat_cnt       <= '0;
                        if (stale || TFT_begin) begin
                            state           <= DRAIN;
                            mem.mem_rd_addr <= BASE_ADDR;
                            stale           <= 1'b0;
                        end else begin
                            state           <= DATA;
                            mem.mem_rd_addr <= mem.mem_rd_addr + BURST_A;
                            fetched         <= fetched + BURST_F;
                        end
                    end else if (TFT_begin) begin
                        stale <= 1'b1;
                    end
                end
                DATA, DRAIN: begin
                    if (beat)      beat_cnt        <= beat_cnt + 1'b1;
                    if (TFT_begin) mem.mem_rd_addr <= BASE_ADDR;
                    if (last_beat)
                        state <= IDLE;
                    else if (TFT_begin)
                        state <= DRAIN;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
